// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC sequencer and instruction-memory port arbiter
// Issues fetch addresses with stall/redirect/halt and lends the port to the loader when not running.
module fetch_sequencer #(
  parameter int          ADDR_W   = 7,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              halt_req,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_data,
  output logic              ld_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       inst_out,
  output logic              inst_valid,
  output logic [31:0]       inst_pc,
  output logic [1:0]        state,
  output logic [31:0]       fetch_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_HALT = 2'b10
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] inst_pc_q;
  logic [31:0] fetch_count_q;
  logic        inst_valid_q;

  // Port mux is combinational so the loader gets one word per cycle and a
  // stall can re-present the held word with no extra latency.
  always_comb begin
    ld_ready  = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = ld_data;
    mem_addr  = '0;
    if (rst_n) begin
      case (state_q)
        S_RUN: begin
          if (halt_req)            mem_addr = pc_q[ADDR_W-1:0];
          else if (redirect_valid) mem_addr = redirect_pc[ADDR_W-1:0];
          else if (stall)          mem_addr = inst_pc_q[ADDR_W-1:0];
          else                     mem_addr = pc_q[ADDR_W-1:0];
        end
        default: begin
          ld_ready = 1'b1;
          mem_we   = ld_valid;
          mem_addr = ld_addr;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      inst_pc_q     <= '0;
      inst_valid_q  <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      if (inst_valid_q && !stall)
        fetch_count_q <= fetch_count_q + 32'd1;
      case (state_q)
        S_RUN: begin
          if (halt_req) begin
            state_q      <= S_HALT;
            inst_valid_q <= 1'b0;
          end else if (redirect_valid) begin
            pc_q         <= redirect_pc + 32'd1;
            inst_pc_q    <= redirect_pc;
            inst_valid_q <= 1'b1;
          end else if (!stall) begin
            pc_q         <= pc_q + 32'd1;
            inst_pc_q    <= pc_q;
            inst_valid_q <= 1'b1;
          end
        end
        S_IDLE, S_HALT: begin
          inst_valid_q <= 1'b0;
          if (start) begin
            state_q <= S_RUN;
            pc_q    <= RESET_PC;
          end
        end
        default: begin
          state_q      <= S_IDLE;
          inst_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign inst_out    = mem_rdata;
  assign inst_valid  = inst_valid_q;
  assign inst_pc     = inst_pc_q;
  assign state       = state_q;
  assign fetch_count = fetch_count_q;

endmodule
